// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift/rotate sequencer: operation modes and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHR = 2'd0,
    MODE_SHL = 2'd1,
    MODE_ROR = 2'd2,
    MODE_ROL = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : shift_seq_pkg

// File: rtl/dff_reg.sv
// WIDTH parallel D flip-flops with synchronous active-high reset and load enable.
module dff_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: clear on reset, capture d when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule : dff_reg

// File: rtl/shift_seq_ctrl.sv
// Sequencer that parallel-loads a register, then applies a programmed number of
// shift/rotate steps one per clock and signals completion with busy/done.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] q_d;
  logic             q_en;

  // One shift/rotate step of the register for the given mode.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur,
                                            input mode_t            m,
                                            input logic             fill);
    case (m)
      MODE_SHR: step = {fill, cur[WIDTH-1:1]};
      MODE_SHL: step = {cur[WIDTH-2:0], fill};
      MODE_ROR: step = {cur[0], cur[WIDTH-1:1]};
      default:  step = {cur[WIDTH-2:0], cur[WIDTH-1]};
    endcase
  endfunction

  dff_reg #(.WIDTH(WIDTH)) u_dff_reg (
    .clk (clk),
    .rst (rst),
    .en  (q_en),
    .d   (q_d),
    .q   (q)
  );

  // Control state: FSM state, latched mode and remaining step count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SHR;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state, register update and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    q_d         = q;
    q_en        = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_en        = 1'b1;
          q_d         = load_val;
          mode_d      = mode_t'(mode);
          remaining_d = (shift_cnt > WIDTH_CNT) ? WIDTH_CNT : shift_cnt;
          state_d     = (remaining_d != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        q_en        = 1'b1;
        q_d         = step(q, mode_q, serial_in);
        remaining_d = remaining_q - ONE_CNT;
        if (remaining_q == ONE_CNT) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit about to leave: LSB for right-going modes, MSB for left-going modes.
  assign serial_out = (mode_q == MODE_SHR || mode_q == MODE_ROR) ? q[0] : q[WIDTH-1];

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=8).
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_val;
  logic [CNT_W-1:0] shift_cnt;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .load_val   (load_val),
    .shift_cnt  (shift_cnt),
    .serial_in  (serial_in),
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns just after the accepting edge.
  task automatic do_start(input logic [7:0] lv, input logic [1:0] m,
                          input logic [CNT_W-1:0] cnt, input logic sin);
    load_val  = lv;
    mode      = m;
    shift_cnt = cnt;
    serial_in = sin;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  logic [7:0] shr_q [4] = '{8'hA5, 8'hD2, 8'hE9, 8'hF4};
  logic [7:0] rol_q [5] = '{8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3};
  logic       rol_so[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] exp_q;
  bit         seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; load_val = '0; shift_cnt = '0; serial_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("por_q", q, 8'h00);
    check("por_busy", busy, 0);
    check("por_done", done, 0);

    // Reset after some activity: rst asserted 2 cycles into a left shift.
    do_start(8'hC7, 2'd1, 4'd4, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", serial_out, 0);

    // Shift right A5 by 3 with fill 1.
    do_start(8'hA5, 2'd0, 4'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("shr_q%0d", i), q, shr_q[i]);
      check($sformatf("shr_sout%0d", i), serial_out, shr_q[i][0]);
      check($sformatf("shr_done%0d", i), done, (i == 3));
      check($sformatf("shr_busy%0d", i), busy, 1);
      if (i < 3) tick();
    end
    tick();
    check("shr_idle_busy", busy, 0);
    check("shr_idle_done", done, 0);
    check("shr_idle_q", q, 8'hF4);

    // Rotate left 3C by 4; serial_out traces q[7].
    do_start(8'h3C, 2'd3, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rol_q%0d", i), q, rol_q[i]);
      check($sformatf("rol_sout%0d", i), serial_out, rol_so[i]);
      if (i < 4) tick();
    end
    check("rol_done", done, 1);
    tick();

    // Zero count: done in the cycle right after acceptance.
    do_start(8'h5A, 2'd2, 4'd0, 1'b0);
    check("zero_q", q, 8'h5A);
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    tick();
    check("zero_idle", busy, 0);
    check("zero_q_hold", q, 8'h5A);

    // Count 9 clamps to 8: shift left FF with fill 0 empties the register.
    do_start(8'hFF, 2'd1, 4'd9, 1'b0);
    check("clamp_q0", q, 8'hFF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_q = 8'hFF << k;
      check($sformatf("clamp_q%0d", k), q, exp_q);
      check($sformatf("clamp_done%0d", k), done, (k == 8));
    end
    tick();
    check("clamp_idle", busy, 0);

    // Start held high while busy: ignored until the first IDLE cycle.
    do_start(8'hF0, 2'd0, 4'd3, 1'b0);
    load_val = 8'h11; mode = 2'd1; shift_cnt = 4'd1; start = 1'b1;
    tick(); check("busy_q1", q, 8'h78);
    tick(); check("busy_q2", q, 8'h3C);
    tick(); check("busy_q3", q, 8'h1E);
    check("busy_done", done, 1);
    tick();
    check("busy_ignored_q", q, 8'h1E);
    check("busy_ignored_idle", busy, 0);
    tick();
    start = 1'b0;
    check("busy_accept_q", q, 8'h11);
    check("busy_accept_busy", busy, 1);
    tick();
    check("busy_new_q", q, 8'h22);
    check("busy_new_done", done, 1);
    tick();

    // Reset at the 2nd shift edge of a 5-step rotate right: no done afterwards.
    do_start(8'h81, 2'd2, 4'd5, 1'b0);
    tick();
    check("midrst_q1", q, 8'hC0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_q", q, 8'h00);
    check("midrst_busy", busy, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("midrst_no_done", seen_done, 0);
    check("midrst_q_hold", q, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_seq_ctrl
